// File: rtl/seg7_glyph_decoder.sv
// ---------------------------------------------------------------------------
// seg7_glyph_decoder
//
// Purpose:
//   Recovers the 4-bit letter index from a 7-segment bus. This is the inverse
//   of the letter-to-segment encoder. A pattern is decoded only after it has
//   been stable for STABLE_CYCLES consecutive samples. The decoded pattern is
//   classified as letter / blank / ambiguous / invalid and handed to the
//   consumer over a valid/ready handshake. The same stable pattern is never
//   emitted twice in a row.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples required (1..255)
//   ACTIVE_LOW     1: seg_in is active-low (0 = lit); 0: seg_in is inverted
//                  before lookup
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   seg_in     in   [6:0] segment bus, bit order g,f,e,d,c,b,a
//   out_ready  in   consumer ready
//   out_valid  out  result available
//   idx_out    out  [3:0] decoded letter index
//   blank_out  out  pattern is dash or all-off
//   amb_out    out  pattern maps to two indices (12/13)
//   err_out    out  pattern not in table
//   err_cnt    out  [7:0] count of transferred invalid results
//
// Optional feature (macro SEG7_ERRCNT_EN):
//   Defined   : err_cnt counts transfers with err_out=1, saturating at 255,
//               cleared only by reset.
//   Undefined : err_cnt is tied to 0 and no counter is built.
// ---------------------------------------------------------------------------
module seg7_glyph_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] idx_out,
  output logic       blank_out,
  output logic       amb_out,
  output logic       err_out,
  output logic [7:0] err_cnt
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
    $error("seg7_glyph_decoder: STABLE_CYCLES must be within 1..255");
  end

  localparam logic [7:0] STABLE_THRESH = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_DARK      = 7'b1111111;

  typedef struct packed {
    logic [3:0] idx;
    logic       blank;
    logic       amb;
    logic       err;
  } glyph_t;

  typedef enum logic {
    TRACK   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Table lookup on an active-low pattern. Flags are mutually exclusive and
  // idx is 0 for anything that is not a letter.
  function automatic glyph_t decode_glyph(input logic [6:0] pat);
    glyph_t g;
    g = '{idx: 4'd0, blank: 1'b0, amb: 1'b0, err: 1'b0};
    case (pat)
      7'b0001000: g.idx = 4'd0;
      7'b0000000: g.idx = 4'd1;
      7'b1000110: g.idx = 4'd2;
      7'b0100001: g.idx = 4'd3;
      7'b0000110: g.idx = 4'd4;
      7'b0001110: g.idx = 4'd5;
      7'b0010000: g.idx = 4'd6;
      7'b0001001: g.idx = 4'd7;
      7'b1111001: g.idx = 4'd8;
      7'b1110001: g.idx = 4'd9;
      7'b1000111: g.idx = 4'd10;
      7'b1000000: g.idx = 4'd11;
      // Letters 12 and 13 render identically; report the lower index.
      7'b0001100: begin
        g.idx = 4'd12;
        g.amb = 1'b1;
      end
      7'b1000001: g.idx = 4'd14;
      7'b0010001: g.idx = 4'd15;
      7'b0111111,
      7'b1111111: g.blank = 1'b1;
      default:    g.err   = 1'b1;
    endcase
    return g;
  endfunction

  // Saturating 8-bit increment shared by the stability and error counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state;
  state_t     state_next;
  logic [6:0] seg_norm;
  logic [6:0] seg_q;
  logic [7:0] stab_cnt;
  logic [6:0] last_emitted;
  logic       same;
  logic       stable;
  logic       emit;
  logic       xfer;
  glyph_t     glyph;

  // Everything downstream works in the active-low domain of the table.
  assign seg_norm = ACTIVE_LOW ? seg_in : ~seg_in;

  assign same   = (seg_norm == seg_q);
  assign stable = same && (stab_cnt >= STABLE_THRESH);
  assign emit   = (state == TRACK) && stable && (seg_q != last_emitted);
  assign xfer   = (state == PRESENT) && out_valid && out_ready;
  assign glyph  = decode_glyph(seg_q);

  // ---- input sampling / stability tracking (runs in every state) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= SEG_DARK;
      stab_cnt <= 8'd0;
    end else begin
      seg_q    <= seg_norm;
      stab_cnt <= same ? sat_inc8(stab_cnt) : 8'd0;
    end
  end

  // ---- control FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TRACK;
    end else begin
      state <= state_next;
    end
  end

  // ---- control FSM: next state ----
  always_comb begin
    state_next = state;
    case (state)
      TRACK:   if (emit) state_next = PRESENT;
      PRESENT: if (xfer) state_next = TRACK;
      default: state_next = TRACK;
    endcase
  end

  // ---- result registers ----
  // last_emitted resets to the dark pattern so an unlit display is not
  // reported right after reset. Results are only latched when entering
  // PRESENT, so input changes while a result is pending leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      idx_out      <= 4'd0;
      blank_out    <= 1'b0;
      amb_out      <= 1'b0;
      err_out      <= 1'b0;
      last_emitted <= SEG_DARK;
    end else if (emit) begin
      out_valid    <= 1'b1;
      idx_out      <= glyph.idx;
      blank_out    <= glyph.blank;
      amb_out      <= glyph.amb;
      err_out      <= glyph.err;
      last_emitted <= seg_q;
    end else if (xfer) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef SEG7_ERRCNT_EN
  // ---- invalid-pattern counter ----
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (xfer && err_out) begin
      err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_glyph_decoder.sv
module tb_seg7_glyph_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'b1111111;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] idx_out;
  logic       blank_out;
  logic       amb_out;
  logic       err_out;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] idx;
    logic       blank;
    logic       amb;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  seg7_glyph_decoder #(
    .STABLE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .idx_out(idx_out),
    .blank_out(blank_out),
    .amb_out(amb_out),
    .err_out(err_out),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference letter table (active-low patterns).
  function automatic exp_t ref_decode(input logic [6:0] p);
    logic [6:0] tbl [16];
    exp_t e;
    tbl = '{7'b0001000, 7'b0000000, 7'b1000110, 7'b0100001,
            7'b0000110, 7'b0001110, 7'b0010000, 7'b0001001,
            7'b1111001, 7'b1110001, 7'b1000111, 7'b1000000,
            7'b0001100, 7'b0001100, 7'b1000001, 7'b0010001};
    e = '{idx: 4'd0, blank: 1'b0, amb: 1'b0, err: 1'b1};
    if (p == 7'b0111111 || p == 7'b1111111) begin
      e.err   = 1'b0;
      e.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (e.err && tbl[i] == p) begin
          e.idx = 4'(i);
          e.err = 1'b0;
          e.amb = (i == 12);
        end
      end
    end
    return e;
  endfunction

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0; seg_in = 7'b1111111; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (idx_out !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", idx_out); end
    checks++; if ({blank_out, amb_out, err_out} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {blank_out, amb_out, err_out}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d want=0", err_cnt); end
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid !== 1'b0) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL dark_no_emit got=%0d valid cycles want=0", n); end
  endtask

  task automatic test_latency;
    exp_t e;
    int n;
    @(negedge clk);
    seg_in = 7'b0001000; out_ready = 1'b1;
    exp_q.push_back(ref_decode(seg_in));
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got=%b want=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    e = exp_q.pop_front();
    checks++; if ({idx_out, blank_out, amb_out, err_out} !== e) begin errors++; $display("FAIL lat_data got=%h want=%h", {idx_out, blank_out, amb_out, err_out}, e); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_xfer got=%b want=0", out_valid); end
    n = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid !== 1'b0) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL lat_no_repeat got=%0d want=0", n); end
  endtask

  task automatic test_backpressure;
    exp_t e;
    bit seen;
    int bad;
    @(negedge clk);
    out_ready = 1'b0; seg_in = 7'b0001100;
    exp_q.push_back(ref_decode(seg_in));
    wait_valid(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL bp_first_timeout got=0 want=1"); end
    e = exp_q.pop_front();
    checks++; if ({idx_out, blank_out, amb_out, err_out} !== e) begin errors++; $display("FAIL bp_first_data got=%h want=%h", {idx_out, blank_out, amb_out, err_out}, e); end
    bad = 0;
    repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b1 || {idx_out, amb_out} !== {4'd12, 1'b1}) bad++; end
    @(negedge clk);
    seg_in = 7'b1000001;
    exp_q.push_back(ref_decode(seg_in));
    repeat (6) begin @(posedge clk); #1; if (out_valid !== 1'b1 || {idx_out, amb_out} !== {4'd12, 1'b1}) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles want=0", bad); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_xfer got=%b want=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%b want=1", out_valid); end
    e = exp_q.pop_front();
    checks++; if ({idx_out, blank_out, amb_out, err_out} !== e) begin errors++; $display("FAIL bp_next_data got=%h want=%h", {idx_out, blank_out, amb_out, err_out}, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_glitch;
    exp_t e;
    bit seen;
    int n;
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seg_in = ((i / 2) % 2 != 0) ? 7'b0001110 : 7'b0000110;
      @(posedge clk); #1;
      if (out_valid !== 1'b0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL glitch_no_emit got=%0d want=0", n); end
    @(negedge clk);
    seg_in = 7'b0111111;
    exp_q.push_back(ref_decode(seg_in));
    wait_valid(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL dash_timeout got=0 want=1"); end
    e = exp_q.pop_front();
    checks++; if ({idx_out, blank_out, amb_out, err_out} !== e) begin errors++; $display("FAIL dash_data got=%h want=%h", {idx_out, blank_out, amb_out, err_out}, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_errcnt;
    exp_t e;
    bit seen;
    int exp_cnt;
    exp_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        seg_in = (j != 0) ? 7'b0000000 : 7'b1010101;
        exp_q.push_back(ref_decode(seg_in));
        wait_valid(20, seen);
        checks++; if (!seen) begin errors++; $display("FAIL errcnt_timeout iter=%0d got=0 want=1", i); end
        e = exp_q.pop_front();
        checks++; if ({idx_out, blank_out, amb_out, err_out} !== e) begin errors++; $display("FAIL errcnt_data iter=%0d got=%h want=%h", i, {idx_out, blank_out, amb_out, err_out}, e); end
        @(posedge clk); #1;
`ifdef SEG7_ERRCNT_EN
        if (e.err && exp_cnt < 255) exp_cnt++;
`endif
        checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL errcnt_value iter=%0d got=%0d want=%0d", i, err_cnt, exp_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid_present;
    exp_t e;
    bit seen;
    @(negedge clk);
    out_ready = 1'b0; seg_in = 7'b1000110;
    exp_q.push_back(ref_decode(seg_in));
    wait_valid(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_timeout got=0 want=1"); end
    e = exp_q.pop_front();
    checks++; if ({idx_out, blank_out, amb_out, err_out} !== e) begin errors++; $display("FAIL rstmid_data got=%h want=%h", {idx_out, blank_out, amb_out, err_out}, e); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, idx_out, blank_out, amb_out, err_out, err_cnt} !== 16'd0) begin
      errors++; $display("FAIL rstmid_async got=%h want=0", {out_valid, idx_out, blank_out, amb_out, err_out, err_cnt});
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ref_decode(seg_in));
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got=%b want=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_reemit got=%b want=1", out_valid); end
    e = exp_q.pop_front();
    checks++; if ({idx_out, blank_out, amb_out, err_out} !== e) begin errors++; $display("FAIL rstmid_reemit_data got=%h want=%h", {idx_out, blank_out, amb_out, err_out}, e); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_glitch();
    test_errcnt();
    test_reset_mid_present();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_glyph_decoder.md
Name: seg7_glyph_decoder

Overview:
- Inverse of the game's letter-to-seven-segment encoder: watches a 7-bit segment bus and recovers the 4-bit letter index.
- Requires a pattern to be stable for a set number of cycles before decoding it.
- Classifies the stable pattern as letter, blank, ambiguous or invalid, and hands the result to the trainer scoring logic over a valid/ready handshake.
- Used to check displayed glyphs against the expected answer and in loopback self-test of the display path.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before decode; legal range 1..255.
- ACTIVE_LOW, 1, 1 = seg_in is active-low (0 = segment lit); 0 = seg_in is inverted internally before lookup.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment bus, bit order [6:0] = g,f,e,d,c,b,a.
- out_ready  in  1  consumer ready.
- out_valid  out  1  result available.
- idx_out  out  4  decoded letter index.
- blank_out  out  1  pattern is dash or all-off.
- amb_out  out  1  pattern maps to two indices.
- err_out  out  1  pattern not in table.
- err_cnt  out  8  invalid-pattern counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, idx_out=0, blank_out=0, amb_out=0, err_out=0, err_cnt=0, seg_q=7'b1111111, stable count=0, last_emitted=7'b1111111, state=TRACK.
- Sampling: seg_q <= normalized seg_in every edge.
  - Stable counter increments, saturating at 255, when normalized seg_in == seg_q; otherwise it clears to 0.
  - Tracking continues in every state.
- Stability condition: counter >= STABLE_CYCLES-1 and normalized seg_in == seg_q.
  - A pattern presented before edge k and held produces out_valid=1 after edge k+STABLE_CYCLES.
- Decode table (active-low pattern -> idx):
  - 0001000->0, 0000000->1, 1000110->2, 0100001->3, 0000110->4, 0001110->5, 0010000->6, 0001001->7.
  - 1111001->8, 1110001->9, 1000111->10, 1000000->11, 0001100->12 with amb_out=1 (13 shares this pattern), 1000001->14, 0010001->15.
  - 0111111 (dash) and 1111111 (dark): blank_out=1, idx_out=0.
  - Any other pattern: err_out=1, idx_out=0.
  - At most one of blank_out, amb_out, err_out is 1.
- FSM states:
  - TRACK: if the stability condition holds and seg_q != last_emitted, go to PRESENT. On that edge, latch the decode of seg_q into the outputs, set out_valid=1 and last_emitted=seg_q.
  - PRESENT: outputs held constant while out_valid=1 and out_ready=0. On the edge where out_valid and out_ready are both 1, the transfer occurs: out_valid=0, go to TRACK.
- No back-to-back transfers: minimum one cycle with out_valid=0 between results.
- Re-emission: the same stable pattern is never emitted twice in a row. A pattern reappearing after a different stable pattern was emitted is emitted again. A glitch that never becomes stable does not re-arm emission.
- Input changes during PRESENT do not alter the held outputs. If the changed pattern is stable and differs from last_emitted when the state returns to TRACK, it is emitted on the next edge.
- out_ready high while out_valid=0 has no effect.
- The reset value of last_emitted suppresses emission of a dark display after reset.
- Reset mid-PRESENT drops the pending result.

Optional Feature:
- Macro: SEG7_ERRCNT_EN.
- Defined:
  - err_cnt increments by 1 on each transfer whose err_out=1.
  - Saturates at 255.
  - Cleared only by reset.
- Undefined: err_cnt is constant 0, no counter logic is built, all other behaviour is identical.

Test Plan:
- Reset, then hold seg_in=7'b1111111 for 20 cycles with out_ready=1 -> out_valid never asserts.
- STABLE_CYCLES=4, drive 0001000 before edge k, out_ready=1 -> out_valid=1 after edge k+4, idx_out=0, all flags 0. Transfer occurs; holding the input produces no second result.
- Drive 0001100 while out_ready=0 for 10 cycles, then change seg_in to 1000001 and raise out_ready -> first transfer is idx 12 with amb_out=1; next result is idx 14 one cycle after the state returns to TRACK.
- Toggle seg_in between 0000110 and 0001110 every 2 cycles for 20 cycles -> no output. Then hold 0111111 -> blank_out=1, idx_out=0.
- With SEG7_ERRCNT_EN, emit 1010101 and 0000000 alternately 300 times (each stable, each accepted) -> err_cnt saturates at 255, every idx 1 result has err_out=0. Without the macro -> err_cnt stays 0.
- Assert rst_n=0 while out_valid=1 -> all outputs 0 immediately (asynchronous). After release with the same letter held, it is re-emitted after STABLE_CYCLES+1 edges.
